dice_turn_sequencer: RTL and testbench

Turn controller for the two-dice DreiMann game. It round-robins the roll right between NUM_PLAYERS players and accepts a roll only from the active player. On an accepted roll it captures both free-running die counters and holds the result for a fixed display window. It then advances the turn, or keeps it with the same player on doubles, and tracks which player currently holds the "Dreimann" role. It sits between the synchronised player buttons, the two running die counters and the display/LED logic.

---
 rtl/dice_pkg.sv | 31 +++
 rtl/rise_detect.sv | 30 +++
 rtl/dice_turn_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_dice_turn_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
// Shared constants and types for the DreiMann dice turn sequencer.
//   DIE_W      width of a die value
//   DIE_MIN    lowest legal die face
//   DIE_MAX    highest legal die face
//   DREI_FACE  face that makes the roller the Dreimann
//   seq_state_e turn FSM states
//   die_valid() true when a running die value shows a legal face
// -----------------------------------------------------------------------------
package dice_pkg;

    localparam int unsigned DIE_W = 3;

    localparam logic [DIE_W-1:0] DIE_MIN   = DIE_W'(1);
    localparam logic [DIE_W-1:0] DIE_MAX   = DIE_W'(6);
    localparam logic [DIE_W-1:0] DREI_FACE = DIE_W'(3);

    typedef enum logic [1:0] {
        StWait    = 2'd0,
        StCapture = 2'd1,
        StShow    = 2'd2,
        StAdvance = 2'd3
    } seq_state_e;

    // The free-running counters briefly pass through 0 and 7; those are not faces.
    function automatic logic die_valid(input logic [DIE_W-1:0] v);
        return (v >= DIE_MIN) && (v <= DIE_MAX);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registers a level vector every cycle and flags bits that went 0 -> 1.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (history cleared to 0)
//   d_i     level inputs, already synchronised
//   rise_o  d_i & ~previous d_i
// -----------------------------------------------------------------------------
module rise_detect #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] rise_o
);

    logic [Width-1:0] d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= '0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/dice_turn_sequencer.sv
// -----------------------------------------------------------------------------
// dice_turn_sequencer
// Turn controller for the two-dice DreiMann game. Accepts a roll only from the
// active player, captures both running dice, holds the result for a display
// window, then passes the turn on (or keeps it on doubles). Tracks the
// current Dreimann holder.
//   clk             clock
//   rst_n           asynchronous active-low reset
//   roll_req        per-player roll buttons (synchronised levels)
//   running_a/b     free-running die values
//   dice_a/b        captured dice, held until the next capture
//   active_player   player whose turn it is
//   drei_mann       current Dreimann holder
//   drei_mann_valid a Dreimann has been assigned
//   pasch           last captured roll was doubles
//   result_valid    one-cycle pulse after a capture
//   busy            turn in progress (not waiting for a button)
// -----------------------------------------------------------------------------
module dice_turn_sequencer
    import dice_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 3,
    parameter int unsigned PLAYER_W    = 2,
    parameter int unsigned SHOW_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PLAYERS-1:0] roll_req,
    input  logic [DIE_W-1:0]       running_a,
    input  logic [DIE_W-1:0]       running_b,
    output logic [DIE_W-1:0]       dice_a,
    output logic [DIE_W-1:0]       dice_b,
    output logic [PLAYER_W-1:0]    active_player,
    output logic [PLAYER_W-1:0]    drei_mann,
    output logic                   drei_mann_valid,
    output logic                   pasch,
    output logic                   result_valid,
    output logic                   busy
);

    localparam int unsigned CntW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CntW-1:0]     CntLoad    = CntW'(SHOW_CYCLES - 1);
    localparam logic [PLAYER_W-1:0] LastPlayer = PLAYER_W'(NUM_PLAYERS - 1);

    // -------------------------------------------------------------------------
    // Button edge detection
    // -------------------------------------------------------------------------
    logic [NUM_PLAYERS-1:0] rise;

    rise_detect #(
        .Width (NUM_PLAYERS)
    ) u_rise_detect (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (roll_req),
        .rise_o (rise)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    seq_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DIE_W-1:0]    dice_a_q, dice_b_q;
    logic                pasch_q;
    logic                result_valid_q;
    logic [PLAYER_W-1:0] active_q;
    logic [PLAYER_W-1:0] drei_q;
    logic                drei_valid_q;

    logic dice_ok;
    logic has_drei;
    logic capture_en;
    logic advance_en;
    logic busy_int;

    assign dice_ok  = die_valid(running_a) && die_valid(running_b);
    assign has_drei = (running_a == DREI_FACE) || (running_b == DREI_FACE);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWait;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWait: begin
                // Only the active player's fresh press counts.
                if (rise[active_q]) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // Counters showing 0 or 7 are re-sampled next cycle.
                if (dice_ok) begin
                    state_d = StShow;
                    cnt_d   = CntLoad;
                end
            end
            StShow: begin
                if (cnt_q == '0) begin
                    state_d = StAdvance;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StAdvance: begin
                state_d = StWait;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    // FSM output decode
    always_comb begin
        capture_en = 1'b0;
        advance_en = 1'b0;
        busy_int   = 1'b1;
        unique case (state_q)
            StWait:    busy_int   = 1'b0;
            StCapture: capture_en = dice_ok;
            StShow:    capture_en = 1'b0;
            StAdvance: advance_en = 1'b1;
            default:   busy_int   = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Result and turn datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dice_a_q       <= '0;
            dice_b_q       <= '0;
            pasch_q        <= 1'b0;
            result_valid_q <= 1'b0;
            active_q       <= '0;
            drei_q         <= '0;
            drei_valid_q   <= 1'b0;
        end else begin
            result_valid_q <= capture_en;
            if (capture_en) begin
                dice_a_q <= running_a;
                dice_b_q <= running_b;
                pasch_q  <= (running_a == running_b);
                if (has_drei) begin
                    drei_q       <= active_q;
                    drei_valid_q <= 1'b1;
                end
            end
            // Doubles keep the turn with the same player.
            if (advance_en && !pasch_q) begin
                if (active_q == LastPlayer) begin
                    active_q <= '0;
                end else begin
                    active_q <= active_q + PLAYER_W'(1);
                end
            end
        end
    end

    assign dice_a          = dice_a_q;
    assign dice_b          = dice_b_q;
    assign pasch           = pasch_q;
    assign result_valid    = result_valid_q;
    assign active_player   = active_q;
    assign drei_mann       = drei_q;
    assign drei_mann_valid = drei_valid_q;
    assign busy            = busy_int;

endmodule

// File: tb/tb_dice_turn_sequencer.sv
module tb_dice_turn_sequencer;

    localparam int NP   = 3;
    localparam int SHOW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] roll_req = '0;
    logic [2:0]    running_a = '0;
    logic [2:0]    running_b = '0;
    logic [2:0]    dice_a, dice_b;
    logic [1:0]    active_player, drei_mann;
    logic          drei_mann_valid, pasch, result_valid, busy;

    dice_turn_sequencer #(
        .NUM_PLAYERS (NP),
        .PLAYER_W    (2),
        .SHOW_CYCLES (SHOW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .roll_req        (roll_req),
        .running_a       (running_a),
        .running_b       (running_b),
        .dice_a          (dice_a),
        .dice_b          (dice_b),
        .active_player   (active_player),
        .drei_mann       (drei_mann),
        .drei_mann_valid (drei_mann_valid),
        .pasch           (pasch),
        .result_valid    (result_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Game-level model: what the players and display should see.
    int exp_active, exp_drei, exp_a, exp_b;
    bit exp_dv, exp_pasch;

    logic [13:0] obs;
    assign obs = {dice_a, dice_b, pasch, drei_mann, drei_mann_valid, active_player,
                  result_valid, busy};

    function automatic logic [13:0] exp_vec(input bit busy_e, input bit rv_e);
        return {3'(exp_a), 3'(exp_b), exp_pasch, 2'(exp_drei), exp_dv, 2'(exp_active),
                rv_e, busy_e};
    endfunction

    function automatic void model_reset();
        exp_active = 0; exp_drei = 0; exp_a = 0; exp_b = 0; exp_dv = 0; exp_pasch = 0;
    endfunction

    function automatic void model_capture(input int a, input int b);
        exp_a = a;
        exp_b = b;
        exp_pasch = (a == b);
        if (a == 3 || b == 3) begin
            exp_drei = exp_active;
            exp_dv = 1;
        end
    endfunction

    function automatic void model_advance();
        if (!exp_pasch) exp_active = (exp_active + 1) % NP;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle button pulse; returns just after the edge that saw the rise.
    task automatic press(input int p);
        roll_req[p] = 1'b1;
        tick();
        roll_req[p] = 1'b0;
    endtask

    // Press then present valid dice; returns just after the capture edge.
    task automatic do_roll(input int p, input int a, input int b);
        press(p);
        running_a = 3'(a);
        running_b = 3'(b);
        tick();
    endtask

    // Remaining SHOW + ADVANCE edges after the capture edge.
    task automatic finish_turn();
        repeat (SHOW + 1) tick();
    endtask

    task automatic test_reset();
        model_reset();
        running_a = 3'($urandom_range(0, 7));
        running_b = 3'($urandom_range(0, 7));
        #3;
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL reset_hold: got %h want %h", obs, exp_vec(0, 0));
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL reset_release: got %h want %h", obs, exp_vec(0, 0));
        end
    endtask

    task automatic test_basic();
        press(0);
        vectors++;
        if (obs !== exp_vec(1, 0)) begin
            miscompares++; $display("FAIL basic_capture_state: got %h want %h", obs, exp_vec(1, 0));
        end
        running_a = 3'd2; running_b = 3'd5;
        tick();
        model_capture(2, 5);
        vectors++;
        if (obs !== exp_vec(1, 1)) begin
            miscompares++; $display("FAIL basic_result: got %h want %h", obs, exp_vec(1, 1));
        end
        tick();
        vectors++;
        if (obs !== exp_vec(1, 0)) begin
            miscompares++; $display("FAIL basic_pulse_end: got %h want %h", obs, exp_vec(1, 0));
        end
        repeat (SHOW - 1) tick();
        vectors++;
        if (obs !== exp_vec(1, 0)) begin
            miscompares++; $display("FAIL basic_advance: got %h want %h", obs, exp_vec(1, 0));
        end
        tick();
        model_advance();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL basic_next_turn: got %h want %h", obs, exp_vec(0, 0));
        end
    endtask

    task automatic test_wrong_player();
        roll_req = 3'b101;
        tick();
        roll_req = '0;
        tick();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL others_ignored: got %h want %h", obs, exp_vec(0, 0));
        end
        do_roll(1, 4, 4);
        model_capture(4, 4);
        vectors++;
        if (obs !== exp_vec(1, 1)) begin
            miscompares++; $display("FAIL pasch_result: got %h want %h", obs, exp_vec(1, 1));
        end
        finish_turn();
        model_advance();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL pasch_keeps_turn: got %h want %h", obs, exp_vec(0, 0));
        end
    endtask

    task automatic test_dreimann();
        int rolls[3][3] = '{'{1, 6, 5}, '{2, 3, 6}, '{0, 1, 2}};
        for (int i = 0; i < 3; i++) begin
            do_roll(rolls[i][0], rolls[i][1], rolls[i][2]);
            model_capture(rolls[i][1], rolls[i][2]);
            vectors++;
            if (obs !== exp_vec(1, 1)) begin
                miscompares++; $display("FAIL drei_capture%0d: got %h want %h", i, obs, exp_vec(1, 1));
            end
            finish_turn();
            model_advance();
            vectors++;
            if (obs !== exp_vec(0, 0)) begin
                miscompares++; $display("FAIL drei_turn%0d: got %h want %h", i, obs, exp_vec(0, 0));
            end
        end
    endtask

    task automatic test_invalid_dice();
        press(exp_active);
        running_a = 3'd0; running_b = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== exp_vec(1, 0)) begin
                miscompares++; $display("FAIL stall%0d: got %h want %h", i, obs, exp_vec(1, 0));
            end
        end
        running_a = 3'd5;
        tick();
        model_capture(5, 1);
        vectors++;
        if (obs !== exp_vec(1, 1)) begin
            miscompares++; $display("FAIL stall_capture: got %h want %h", obs, exp_vec(1, 1));
        end
        tick();
        vectors++;
        if (obs !== exp_vec(1, 0)) begin
            miscompares++; $display("FAIL stall_single_pulse: got %h want %h", obs, exp_vec(1, 0));
        end
        repeat (SHOW) tick();
        model_advance();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL stall_turn: got %h want %h", obs, exp_vec(0, 0));
        end
    endtask

    task automatic test_held_button();
        int p = exp_active;
        roll_req[p] = 1'b1;
        tick();
        running_a = 3'd4; running_b = 3'd4;
        tick();
        model_capture(4, 4);
        vectors++;
        if (obs !== exp_vec(1, 1)) begin
            miscompares++; $display("FAIL held_capture: got %h want %h", obs, exp_vec(1, 1));
        end
        finish_turn();
        model_advance();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== exp_vec(0, 0)) begin
                miscompares++; $display("FAIL held_no_retrigger%0d: got %h want %h", i, obs, exp_vec(0, 0));
            end
        end
        roll_req[p] = 1'b0;
        tick();
        do_roll(p, 1, 5);
        model_capture(1, 5);
        vectors++;
        if (obs !== exp_vec(1, 1)) begin
            miscompares++; $display("FAIL held_repress: got %h want %h", obs, exp_vec(1, 1));
        end
        finish_turn();
        model_advance();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL held_turn: got %h want %h", obs, exp_vec(0, 0));
        end
    endtask

    task automatic test_reset_mid_roll();
        do_roll(exp_active, 2, 6);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL async_reset: got %h want %h", obs, exp_vec(0, 0));
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        do_roll(0, 5, 6);
        model_capture(5, 6);
        vectors++;
        if (obs !== exp_vec(1, 1)) begin
            miscompares++; $display("FAIL after_reset_capture: got %h want %h", obs, exp_vec(1, 1));
        end
        finish_turn();
        model_advance();
        vectors++;
        if (obs !== exp_vec(0, 0)) begin
            miscompares++; $display("FAIL after_reset_turn: got %h want %h", obs, exp_vec(0, 0));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                press((exp_active + 1 + $urandom_range(0, NP - 2)) % NP);
                tick();
                vectors++;
                if (obs !== exp_vec(0, 0)) begin
                    miscompares++; $display("FAIL rnd_wrong%0d: got %h want %h", n, obs, exp_vec(0, 0));
                end
            end else begin
                int a = $urandom_range(1, 6);
                int b = $urandom_range(1, 6);
                int stalls = $urandom_range(0, 2);
                press(exp_active);
                for (int s = 0; s < stalls; s++) begin
                    running_a = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd7;
                    running_b = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) != 0) begin
                        running_b = running_a;
                        running_a = 3'($urandom_range(0, 7));
                    end
                    tick();
                    vectors++;
                    if (obs !== exp_vec(1, 0)) begin
                        miscompares++; $display("FAIL rnd_stall%0d: got %h want %h", n, obs, exp_vec(1, 0));
                    end
                end
                running_a = 3'(a);
                running_b = 3'(b);
                tick();
                model_capture(a, b);
                vectors++;
                if (obs !== exp_vec(1, 1)) begin
                    miscompares++; $display("FAIL rnd_capture%0d: got %h want %h", n, obs, exp_vec(1, 1));
                end
                repeat (SHOW) tick();
                vectors++;
                if (obs !== exp_vec(1, 0)) begin
                    miscompares++; $display("FAIL rnd_show%0d: got %h want %h", n, obs, exp_vec(1, 0));
                end
                tick();
                model_advance();
                vectors++;
                if (obs !== exp_vec(0, 0)) begin
                    miscompares++; $display("FAIL rnd_turn%0d: got %h want %h", n, obs, exp_vec(0, 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrong_player();
        test_dreimann();
        test_invalid_dice();
        test_held_button();
        test_reset_mid_roll();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
